// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory bus arbiter.
// FSM state and grant-owner encodings.
package mem_arb_pkg;
  localparam int EN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } arb_owner_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic                           m0_req, m1_req;
  logic                           m0_wea, m1_wea;
  logic [mem_arb_pkg::EN_W-1:0]   m0_en, m1_en;
  logic [AW-1:0]                  m0_addr, m1_addr;
  logic [DW-1:0]                  m0_din, m1_din;
  logic                           m0_ack, m1_ack;
  logic [DW-1:0]                  m0_dout, m1_dout;
  logic                           mem_wea, mem_rea;
  logic [mem_arb_pkg::EN_W-1:0]   mem_en;
  logic [AW-1:0]                  mem_addr;
  logic [DW-1:0]                  mem_din;
  logic [DW-1:0]                  mem_dout;
  logic                           mem_hold;

  modport slave (
    input  m0_req, m1_req, m0_wea, m1_wea, m0_en, m1_en,
           m0_addr, m1_addr, m0_din, m1_din, mem_dout, mem_hold,
    output m0_ack, m1_ack, m0_dout, m1_dout,
           mem_wea, mem_rea, mem_en, mem_addr, mem_din
  );

  modport master (
    output m0_req, m1_req, m0_wea, m1_wea, m0_en, m1_en,
           m0_addr, m1_addr, m0_din, m1_din, mem_dout, mem_hold,
    input  m0_ack, m1_ack, m0_dout, m1_dout,
           mem_wea, mem_rea, mem_en, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: IDLE -> ISSUE (stalls on mem_hold) -> RESP.
// Define MEM_ARB_FAIR_EN to force a switch after MAX_RUN consecutive grants.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_RUN = 8
) (
  input logic              clk,
  input logic              Rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int               RUN_W   = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d, grant;
  logic             wea_q, wea_d;
  logic [EN_W-1:0]  en_q, en_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    din_q, din_d;
  logic [DW-1:0]    m0_dout_q, m0_dout_d, m1_dout_q, m1_dout_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             at_max, rd_resp;

  // Loader wins ties unless the run limit says the previous owner must yield.
  function automatic arb_owner_t pick_owner(input logic r0, input logic r1,
                                            input arb_owner_t last, input logic force_sw);
    arb_owner_t p;
    p = r1 ? OWN_M1 : OWN_M0;
    if (r0 && r1 && force_sw && (p == last))
      p = (last == OWN_M1) ? OWN_M0 : OWN_M1;
    return p;
  endfunction

`ifdef MEM_ARB_FAIR_EN
  assign at_max = (run_q == RUN_MAX);
`else
  assign at_max = 1'b0;
`endif

  assign grant = pick_owner(bus.m0_req, bus.m1_req, owner_q, at_max);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_M0;
      wea_q     <= 1'b0;
      en_q      <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wea_q     <= wea_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wea_d     = wea_q;
    en_d      = en_q;
    addr_d    = addr_q;
    din_d     = din_q;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;
    run_d     = run_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = ISSUE;
          owner_d = grant;
          if (grant == OWN_M1) begin
            wea_d  = bus.m1_wea;
            en_d   = bus.m1_en;
            addr_d = bus.m1_addr;
            din_d  = bus.m1_din;
          end else begin
            wea_d  = bus.m0_wea;
            en_d   = bus.m0_en;
            addr_d = bus.m0_addr;
            din_d  = bus.m0_din;
          end
          if (grant != owner_q)     run_d = RUN_W'(1);
          else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
        end
      end
      ISSUE: begin
        if (!bus.mem_hold) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (!wea_q) begin
          if (owner_q == OWN_M1) m1_dout_d = bus.mem_dout;
          else                   m0_dout_d = bus.mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded during RESP so it is valid alongside the ack.
  assign rd_resp      = (state_q == RESP) && !wea_q;
  assign bus.mem_wea  = (state_q == ISSUE) && wea_q;
  assign bus.mem_rea  = (state_q == ISSUE) && !wea_q;
  assign bus.mem_en   = (state_q == ISSUE) ? en_q : '0;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.m0_ack   = (state_q == RESP) && (owner_q == OWN_M0);
  assign bus.m1_ack   = (state_q == RESP) && (owner_q == OWN_M1);
  assign bus.m0_dout  = (rd_resp && owner_q == OWN_M0) ? bus.mem_dout : m0_dout_q;
  assign bus.m1_dout  = (rd_resp && owner_q == OWN_M1) ? bus.mem_dout : m1_dout_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; expected ack order follows MEM_ARB_FAIR_EN.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  logic clk;
  logic Rst;
  int   checks;
  int   errors;
  logic [5:0]  m0_pat;
  logic        exp_m0, exp_m1;
  logic [31:0] exp_dout;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32), .MAX_RUN(2)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef MEM_ARB_FAIR_EN
    m0_pat = 6'b100100;
`else
    m0_pat = 6'b000000;
`endif
    Rst = 1'b1;
    bus.m0_req = 0; bus.m0_wea = 0; bus.m0_en = '0; bus.m0_addr = '0; bus.m0_din = '0;
    bus.m1_req = 0; bus.m1_wea = 0; bus.m1_en = '0; bus.m1_addr = '0; bus.m1_din = '0;
    bus.mem_dout = '0; bus.mem_hold = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_ack", bus.m0_ack, 0);
    chk("rst_m1_ack", bus.m1_ack, 0);
    chk("rst_mem_wea", bus.mem_wea, 0);
    chk("rst_mem_rea", bus.mem_rea, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_m0_dout", bus.m0_dout, 0);
    chk("rst_m1_dout", bus.m1_dout, 0);
    Rst = 1'b0;

    // single read by m0
    @(negedge clk);
    bus.m0_req = 1; bus.m0_wea = 0; bus.m0_addr = 32'h10; bus.m0_en = 4'hF;
    #1;
    chk("rd_idle_rea", bus.mem_rea, 0);
    chk("rd_idle_ack", bus.m0_ack, 0);
    @(negedge clk);
    bus.mem_dout = 32'hDEADBEEF;
    #1;
    chk("rd_issue_rea", bus.mem_rea, 1);
    chk("rd_issue_wea", bus.mem_wea, 0);
    chk("rd_issue_addr", bus.mem_addr, 32'h10);
    chk("rd_issue_en", bus.mem_en, 4'hF);
    chk("rd_issue_ack", bus.m0_ack, 0);
    @(negedge clk);
    #1;
    chk("rd_resp_ack", bus.m0_ack, 1);
    chk("rd_resp_m1ack", bus.m1_ack, 0);
    chk("rd_resp_dout", bus.m0_dout, 32'hDEADBEEF);
    chk("rd_resp_rea", bus.mem_rea, 0);
    chk("rd_resp_en", bus.mem_en, 0);
    bus.m0_req = 0;
    @(negedge clk);
    bus.mem_dout = 32'h0;
    #1;
    chk("rd_after_ack", bus.m0_ack, 0);
    chk("rd_dout_held", bus.m0_dout, 32'hDEADBEEF);
    chk("rd_addr_held", bus.mem_addr, 32'h10);

    // m1 write with 4 hold cycles
    @(negedge clk);
    bus.m1_req = 1; bus.m1_wea = 1; bus.m1_addr = 32'h20; bus.m1_din = 32'hA5A5A5A5;
    bus.m1_en = 4'hF; bus.mem_hold = 1;
    #1;
    chk("wr_idle_wea", bus.mem_wea, 0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) bus.mem_hold = 0;
      #1;
      chk($sformatf("wr_c%0d_wea", c), bus.mem_wea, 1);
      chk($sformatf("wr_c%0d_rea", c), bus.mem_rea, 0);
      chk($sformatf("wr_c%0d_din", c), bus.mem_din, 32'hA5A5A5A5);
      chk($sformatf("wr_c%0d_ack", c), bus.m1_ack, 0);
    end
    @(negedge clk);
    bus.mem_dout = 32'h12345678;
    #1;
    chk("wr_c7_ack", bus.m1_ack, 1);
    chk("wr_c7_m0ack", bus.m0_ack, 0);
    chk("wr_c7_wea", bus.mem_wea, 0);
    chk("wr_c7_m1dout", bus.m1_dout, 0);
    chk("wr_c7_m0dout", bus.m0_dout, 32'hDEADBEEF);
    bus.m1_req = 0; bus.m1_wea = 0;
    @(negedge clk);
    #1;
    chk("wr_after_ack", bus.m1_ack, 0);
    chk("wr_m1dout_kept", bus.m1_dout, 0);

    // reset while in ISSUE, then a pending m0 read
    @(negedge clk);
    bus.m1_req = 1; bus.m1_wea = 1; bus.m1_addr = 32'h50; bus.m1_din = 32'h77; bus.mem_hold = 1;
    @(negedge clk);
    #1;
    chk("mr_issue_wea", bus.mem_wea, 1);
    #2;
    Rst = 1'b1;
    bus.m1_req = 0; bus.mem_hold = 0;
    bus.m0_req = 1; bus.m0_wea = 0; bus.m0_addr = 32'h60; bus.m0_en = 4'h3;
    #1;
    chk("mr_rst_wea", bus.mem_wea, 0);
    chk("mr_rst_en", bus.mem_en, 0);
    chk("mr_rst_m1ack", bus.m1_ack, 0);
    chk("mr_rst_addr", bus.mem_addr, 0);
    chk("mr_rst_m0dout", bus.m0_dout, 0);
    @(negedge clk);
    #1;
    chk("mr_rst_hold_ack0", bus.m0_ack, 0);
    chk("mr_rst_hold_ack1", bus.m1_ack, 0);
    chk("mr_rst_hold_rea", bus.mem_rea, 0);
    Rst = 1'b0;
    @(negedge clk);
    bus.mem_dout = 32'h600DF00D;
    #1;
    chk("mr_issue_rea", bus.mem_rea, 1);
    chk("mr_issue_addr", bus.mem_addr, 32'h60);
    chk("mr_issue_en", bus.mem_en, 4'h3);
    @(negedge clk);
    #1;
    chk("mr_resp_ack", bus.m0_ack, 1);
    chk("mr_resp_m1ack", bus.m1_ack, 0);
    chk("mr_resp_dout", bus.m0_dout, 32'h600DF00D);
    bus.m0_req = 0;
    @(negedge clk);
    #1;
    chk("mr_after_ack", bus.m0_ack, 0);

    // contention from a clean reset
    @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    bus.m0_req = 1; bus.m0_wea = 0; bus.m0_addr = 32'h30; bus.m0_en = 4'hF;
    bus.m1_req = 1; bus.m1_wea = 0; bus.m1_addr = 32'h40; bus.m1_en = 4'hF;
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) @(negedge clk);
      bus.mem_dout = 32'hC0DE0000 + 32'(c);
      #1;
      exp_m0 = 1'b0;
      exp_m1 = 1'b0;
      if (c % 3 == 0) begin
        exp_m0 = m0_pat[c/3 - 1];
        exp_m1 = !exp_m0;
      end
      exp_dout = 32'hC0DE0000 + 32'(c);
      chk($sformatf("ct_c%0d_m0ack", c), bus.m0_ack, exp_m0);
      chk($sformatf("ct_c%0d_m1ack", c), bus.m1_ack, exp_m1);
      chk($sformatf("ct_c%0d_onehot", c), bus.m0_ack & bus.m1_ack, 0);
      if (exp_m0) chk($sformatf("ct_c%0d_m0dout", c), bus.m0_dout, exp_dout);
      if (exp_m1) chk($sformatf("ct_c%0d_m1dout", c), bus.m1_dout, exp_dout);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);
    #1;
    chk("ct_end_m0ack", bus.m0_ack, 0);
    chk("ct_end_m1ack", bus.m1_ack, 0);
    chk("ct_end_m0dout", bus.m0_dout, (m0_pat == 6'b0) ? 32'h0 : 32'hC0DE0012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width of both requesters and the memory port.
REQ-002 SHALL have parameter DW, default 32: data width of both requesters and the memory port.
REQ-003 SHALL have parameter MAX_RUN, default 8: consecutive grants to one requester before a forced switch (used only when MEM_ARB_FAIR_EN is defined).
REQ-004 SHALL have port clk  in  1: single clock; all state on its rising edge.
REQ-005 SHALL have port Rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have ports m0_req/m1_req  in  1 each: transaction request from requester 0 (core data) and requester 1 (UART loader); held high until the matching ack.
REQ-007 SHALL have ports m0_wea/m1_wea  in  1: write (1) or read (0).
REQ-008 SHALL have ports m0_en/m1_en  in  4: byte enables.
REQ-009 SHALL have ports m0_addr/m1_addr  in  AW: address.
REQ-010 SHALL have ports m0_din/m1_din  in  DW: write data.
REQ-011 SHALL have ports m0_ack/m1_ack  out  1: one-cycle completion pulse.
REQ-012 SHALL have ports m0_dout/m1_dout  out  DW: read data, valid with ack and held until the next ack.
REQ-013 SHALL have ports mem_wea, mem_rea  out  1; mem_en  out  4; mem_addr  out  AW; mem_din  out  DW: memory-side command.
REQ-014 SHALL have ports mem_dout  in  DW and mem_hold  in  1: memory read data and memory-busy stall.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 IDLE: with any req high, SHALL pick an owner, latch its wea/en/addr/din into a command register, and go to ISSUE next cycle.
REQ-017 ISSUE: SHALL drive the latched command on mem_*, with mem_rea = ~wea and mem_wea = wea; SHALL remain in ISSUE while mem_hold = 1 and go to RESP on the first cycle mem_hold = 0.
REQ-018 RESP: SHALL deassert all mem_* strobes, capture mem_dout into the owner's dout (reads only; writes leave dout unchanged), pulse the owner's ack, and return to IDLE.
REQ-019 Minimum latency, req seen in IDLE to ack: 3 cycles (IDLE, ISSUE, RESP).
REQ-020 Outside ISSUE, mem_wea, mem_rea and mem_en SHALL be 0, and mem_addr/mem_din SHALL hold their last values.
REQ-021 Simultaneous m0_req and m1_req in IDLE: grant SHALL follow REQ-026/027.
REQ-022 A req deasserted before its ack is a protocol violation; the latched transaction SHALL still complete and ack.
REQ-023 The requester acked in RESP SHALL NOT be regranted from the same req level; a new request requires req to be sampled high in IDLE on a later cycle.
REQ-024 At most one ack SHALL be high in any cycle.

Reset
REQ-025 Rst SHALL immediately (asynchronously) force IDLE, all acks 0, mem strobes 0, mem_addr/mem_din/m*_dout 0, and run counter 0; a transaction in flight SHALL be dropped without ack.

Configuration
REQ-026 Without MEM_ARB_FAIR_EN, SHALL use fixed priority: requester 1 (loader) wins every simultaneous request.
REQ-027 With MEM_ARB_FAIR_EN, SHALL count consecutive grants to the same requester; when the count reaches MAX_RUN and the other req is high, the other requester SHALL win and the count SHALL reset to 1; otherwise REQ-026 priority applies.

Structure
REQ-028 SHALL place the FSM state enum (arb_state_t) and an owner typedef (arb_owner_t) in shared package mem_arb_pkg.
REQ-029 SHALL be a single module with no sub-module; the grant-select logic SHALL be a combinational function inside it.

Verification
REQ-030 Single read: m0 reads 0x0000_0010, mem_dout = 0xDEADBEEF -> mem_rea = 1 for one cycle, m0_ack 3 cycles after req, m0_dout = 0xDEADBEEF.
REQ-031 Hold stall: m1 writes 0xA5A5A5A5 to 0x20 with en = 4'hF and mem_hold = 1 for 4 cycles -> mem_wea held 5 cycles, m1_ack on the 7th cycle, m0_dout unchanged.
REQ-032 Contention, fixed priority: m0 and m1 both request continuously -> m1 acked every 3 cycles and m0 never acked.
REQ-033 Contention with MEM_ARB_FAIR_EN and MAX_RUN = 2: both request continuously -> ack order m1, m1, m0, m1, m1, m0.
REQ-034 Reset mid-ISSUE: Rst asserted during ISSUE -> same-cycle mem strobes 0, no ack; after release, a pending m0 read completes normally.
